// File: rtl/cbm_pkg.sv
// cbm_pkg: shared definitions for the column bypass multiplier and its issue
// arbiter.
//   XLEN        operand / result width
//   RD_W        destination register tag width
//   arb_state_t issue arbiter FSM states
//   popcount32  set-bit count of a 32-bit word. It sets CBM latency and drives
//               the operand swap decision.
package cbm_pkg;

   localparam int XLEN = 32;
   localparam int RD_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   function automatic logic [5:0] popcount32(input logic [XLEN-1:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < XLEN; i++) begin
         n = n + {5'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/column_bypass_multiplier.sv
// column_bypass_multiplier: iterative shift-add multiplier. It skips the zero
// columns of op_a and spends one busy cycle per set bit of op_a.
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i            one-cycle start strobe that loads the operands
//   op_a_i, op_b_i     multiplicand (iterated) and multiplier
//   rd_idx_i           destination tag; this instance carries no tag
//   done_o             one-cycle pulse after popcount(op_a) busy cycles
//   result_o           low XLEN bits of op_a*op_b, valid with done_o
module column_bypass_multiplier
   import cbm_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic [RD_W-1:0] rd_idx_i,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   logic            busy_q;
   logic [XLEN-1:0] a_rem_q;
   logic [XLEN-1:0] b_q;
   logic [XLEN-1:0] acc_q;
   logic [4:0]      low_idx;
   logic [XLEN-1:0] a_next;
   logic [XLEN-1:0] acc_next;
   logic            rd_unused;

   assign rd_unused = ^rd_idx_i;

   // Lowest set column of the remaining multiplicand. Its shifted partial
   // product is added in this cycle, and the bit is then cleared.
   always_comb begin
      low_idx = '0;
      for (int i = XLEN - 1; i >= 0; i--) begin
         if (a_rem_q[i]) low_idx = i[4:0];
      end
      a_next   = a_rem_q & (a_rem_q - 1'b1);
      acc_next = acc_q + (b_q << low_idx);
   end

   // Control: a zero multiplicand finishes immediately after the start cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (start_i) begin
            busy_q <= (op_a_i != '0);
            done_o <= (op_a_i == '0);
         end else if (busy_q && (a_next == '0)) begin
            busy_q <= 1'b0;
            done_o <= 1'b1;
         end
      end
   end

   // Datapath
   always_ff @(posedge clk_i) begin
      if (start_i) begin
         a_rem_q  <= op_a_i;
         b_q      <= op_b_i;
         acc_q    <= '0;
         result_o <= '0;
      end else if (busy_q) begin
         a_rem_q <= a_next;
         acc_q   <= acc_next;
         if (a_next == '0) result_o <= acc_next;
      end
   end

endmodule

// File: rtl/cbm_issue_arbiter.sv
// cbm_issue_arbiter: shares one column_bypass_multiplier between two issue
// requesters. It arbitrates round-robin. It optionally swaps the operands so
// the sparser one is iterated. It holds one tagged result for writeback and
// supports flush.
//   clk_i, rst_i                 clock, synchronous active-high reset
//   reqN_valid_i/ready_o         requester N handshake; ready is combinational
//   reqN_a_i, reqN_b_i, reqN_rd_i operands and destination tag
//   flush_i                      kills the pending or in-flight operation
//   resp_valid_o/ready_i         result handshake toward writeback
//   resp_result_o/rd_o/src_o     low product bits, tag, issuing requester
//   busy_o                       FSM is not idle
//   swap_count_o                 saturating count of swapped issues
module cbm_issue_arbiter
   import cbm_pkg::*;
#(
   parameter bit SWAP_EN = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [XLEN-1:0]  req0_a_i,
   input  logic [XLEN-1:0]  req0_b_i,
   input  logic [RD_W-1:0]  req0_rd_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [XLEN-1:0]  req1_a_i,
   input  logic [XLEN-1:0]  req1_b_i,
   input  logic [RD_W-1:0]  req1_rd_i,
   input  logic             flush_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [XLEN-1:0]  resp_result_o,
   output logic [RD_W-1:0]  resp_rd_o,
   output logic             resp_src_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] swap_count_o
);

   arb_state_t      state_q;
   logic            last_grant_q;
   logic            kill_q;
   logic            gnt0, gnt1, hs, do_swap, cbm_start, cbm_done;
   logic [XLEN-1:0] sel_a, sel_b, cbm_result;
   logic [RD_W-1:0] sel_rd;
   logic [XLEN-1:0] iss_a_p0, iss_b_p0;
   logic [RD_W-1:0] iss_rd_p0;
   logic            iss_src_p0;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // A lone valid requester always wins. On contention, the side not served
   // last time wins.
   always_comb begin
      gnt0    = req0_valid_i & (~req1_valid_i | last_grant_q);
      gnt1    = req1_valid_i & (~req0_valid_i | ~last_grant_q);
      sel_a   = gnt1 ? req1_a_i  : req0_a_i;
      sel_b   = gnt1 ? req1_b_i  : req0_b_i;
      sel_rd  = gnt1 ? req1_rd_i : req0_rd_i;
      do_swap = SWAP_EN && (popcount32(sel_b) < popcount32(sel_a));
   end

   assign req0_ready_o = gnt0 & (state_q == IDLE) & ~flush_i & ~rst_i;
   assign req1_ready_o = gnt1 & (state_q == IDLE) & ~flush_i & ~rst_i;
   assign hs           = req0_ready_o | req1_ready_o;
   assign cbm_start    = (state_q == START);

   // Issue stage: the CBM iterates over iss_a_p0. The low product bits are
   // commutative, so a swap does not change the result.
   always_ff @(posedge clk_i) begin
      if (hs) begin
         iss_a_p0   <= do_swap ? sel_b : sel_a;
         iss_b_p0   <= do_swap ? sel_a : sel_b;
         iss_rd_p0  <= sel_rd;
         iss_src_p0 <= gnt1;
      end
   end

   column_bypass_multiplier u_cbm (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (cbm_start),
      .op_a_i   (iss_a_p0),
      .op_b_i   (iss_b_p0),
      .rd_idx_i ('0),
      .done_o   (cbm_done),
      .result_o (cbm_result)
   );

   // Control FSM and response stage. The CBM cannot abort, so a killed
   // operation still occupies the unit until done_o.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         last_grant_q  <= 1'b1;
         kill_q        <= 1'b0;
         resp_valid_o  <= 1'b0;
         resp_result_o <= '0;
         resp_rd_o     <= '0;
         resp_src_o    <= 1'b0;
         busy_o        <= 1'b0;
         swap_count_o  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hs) begin
                  state_q      <= START;
                  busy_o       <= 1'b1;
                  last_grant_q <= gnt1;
                  if (do_swap) swap_count_o <= sat_inc(swap_count_o);
               end
            end
            START: begin
               state_q <= RUN;
               if (flush_i) kill_q <= 1'b1;
            end
            RUN: begin
               if (cbm_done) begin
                  if (kill_q | flush_i) begin
                     state_q <= IDLE;
                     busy_o  <= 1'b0;
                     kill_q  <= 1'b0;
                  end else begin
                     state_q       <= RESP;
                     resp_valid_o  <= 1'b1;
                     resp_result_o <= cbm_result;
                     resp_rd_o     <= iss_rd_p0;
                     resp_src_o    <= iss_src_p0;
                  end
               end else if (flush_i) begin
                  kill_q <= 1'b1;
               end
            end
            RESP: begin
               if (flush_i | resp_ready_i) begin
                  state_q      <= IDLE;
                  busy_o       <= 1'b0;
                  resp_valid_o <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cbm_issue_arbiter.sv
// tb_cbm_issue_arbiter: directed scoreboard bench for cbm_issue_arbiter.
module tb_cbm_issue_arbiter;

   logic        clk;
   logic        rst_i;
   logic        req0_valid_i, req1_valid_i;
   logic        req0_ready_o, req1_ready_o;
   logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
   logic [4:0]  req0_rd_i, req1_rd_i;
   logic        flush_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_result_o;
   logic [4:0]  resp_rd_o;
   logic        resp_src_o;
   logic        busy_o;
   logic [15:0] swap_count_o;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        src;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;
   int   swcnt_exp = 0;
   int   lat_exp   = 0;

   cbm_issue_arbiter #(.SWAP_EN(1'b1), .CNT_W(16)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .req0_valid_i  (req0_valid_i),
      .req0_ready_o  (req0_ready_o),
      .req0_a_i      (req0_a_i),
      .req0_b_i      (req0_b_i),
      .req0_rd_i     (req0_rd_i),
      .req1_valid_i  (req1_valid_i),
      .req1_ready_o  (req1_ready_o),
      .req1_a_i      (req1_a_i),
      .req1_b_i      (req1_b_i),
      .req1_rd_i     (req1_rd_i),
      .flush_i       (flush_i),
      .resp_valid_o  (resp_valid_o),
      .resp_ready_i  (resp_ready_i),
      .resp_result_o (resp_result_o),
      .resp_rd_o     (resp_rd_o),
      .resp_src_o    (resp_src_o),
      .busy_o        (busy_o),
      .swap_count_o  (swap_count_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic int pc(input logic [31:0] v);
      return $countones(v);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   task automatic drive(input bit s, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      if (s) begin
         req1_valid_i = v; req1_a_i = a; req1_b_i = b; req1_rd_i = rd;
      end else begin
         req0_valid_i = v; req0_a_i = a; req0_b_i = b; req0_rd_i = rd;
      end
   endtask

   // Reference model for one accepted request: product, swap, latency.
   task automatic expect_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input bit keep);
      logic [31:0] p;
      bit          sw;
      p  = a * b;
      sw = (pc(b) < pc(a));
      if (sw && swcnt_exp < 65535) swcnt_exp++;
      lat_exp = 3 + pc(sw ? b : a);
      if (keep) exp_q.push_back('{p, rd, s});
   endtask

   // Drives a request at a negedge and returns at the negedge after the handshake.
   task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit keep);
      int n;
      drive(s, 1'b1, a, b, rd);
      n = 0;
      #1;
      while (!(s ? req1_ready_o : req0_ready_o) && n < 64) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 64) chk("grant_timeout", 32'(s ? req1_ready_o : req0_ready_o), 32'd1);
      expect_op(s, a, b, rd, keep);
      @(negedge clk);
      drive(s, 1'b0, a, b, rd);
   endtask

   // Counts negedges from the START cycle (1) to the first one showing resp_valid_o.
   task automatic wait_valid(input string tag);
      int n;
      n = 1;
      while (!resp_valid_o && n < 100) begin
         @(negedge clk); n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(lat_exp));
   endtask

   task automatic accept(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk({tag, "_unexpected_resp"}, 32'(resp_valid_o), 32'd0);
         return;
      end
      e = exp_q.pop_front();
      chk({tag, "_valid"},  32'(resp_valid_o), 32'd1);
      chk({tag, "_result"}, resp_result_o, e.res);
      chk({tag, "_rd"},     32'(resp_rd_o), 32'(e.rd));
      chk({tag, "_src"},    32'(resp_src_o), 32'(e.src));
      resp_ready_i = 1'b1;
      @(negedge clk);
      chk({tag, "_idle_after"}, 32'(busy_o), 32'd0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      exp_q.delete();
      swcnt_exp = 0;
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_resp_valid"}, 32'(resp_valid_o), 32'd0);
      chk({tag, "_busy"},       32'(busy_o), 32'd0);
      chk({tag, "_result"},     resp_result_o, 32'd0);
      chk({tag, "_rd"},         32'(resp_rd_o), 32'd0);
      chk({tag, "_src"},        32'(resp_src_o), 32'd0);
      chk({tag, "_swap_cnt"},   32'(swap_count_o), 32'd0);
      chk({tag, "_ready0"},     32'(req0_ready_o), 32'd0);
      chk({tag, "_ready1"},     32'(req1_ready_o), 32'd0);
   endtask

   initial begin
      bit          g;
      int          n;
      logic [31:0] ra, rb;
      exp_t        e;

      rst_i = 1'b1; flush_i = 1'b0; resp_ready_i = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst_i = 1'b0;
      @(negedge clk);
      chk("reset_busy_after", 32'(busy_o), 32'd0);

      // Swap: iterate over b=3, two busy cycles
      issue(1'b0, 32'hFFFF0000, 32'd3, 5'd5, 1'b1);
      wait_valid("swap");
      chk("swap_result_lit", resp_result_o, 32'hFFFD0000);
      chk("swap_cnt", 32'(swap_count_o), 32'(swcnt_exp));
      chk("swap_cnt_lit", 32'(swap_count_o), 32'd1);
      accept("swap");

      // Fairness from reset: both valid every cycle
      do_reset();
      drive(1'b0, 1'b1, $urandom, $urandom, 5'd10);
      drive(1'b1, 1'b1, $urandom, $urandom, 5'd21);
      for (int k = 0; k < 4; k++) begin
         n = 0;
         #1;
         while (!(req0_ready_o | req1_ready_o) && n < 64) begin
            @(negedge clk); #1; n++;
         end
         g = req1_ready_o;
         chk($sformatf("fair_grant%0d", k), 32'(g), 32'(k % 2));
         if (g) expect_op(1'b1, req1_a_i, req1_b_i, req1_rd_i, 1'b1);
         else   expect_op(1'b0, req0_a_i, req0_b_i, req0_rd_i, 1'b1);
         @(negedge clk);
         drive(g, 1'b1, $urandom, $urandom, g ? 5'd21 : 5'd10);
         wait_valid($sformatf("fair%0d", k));
         accept($sformatf("fair%0d", k));
      end
      drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);

      // Zero operand: no swap, zero busy cycles
      n = swcnt_exp;
      issue(1'b1, 32'd0, 32'd12345, 5'd3, 1'b1);
      wait_valid("zero");
      chk("zero_result_lit", resp_result_o, 32'd0);
      chk("zero_swap_cnt", 32'(swap_count_o), 32'(n));
      accept("zero");

      // Backpressure: result held for 5 cycles with ready low
      resp_ready_i = 1'b0;
      issue(1'b0, 32'd5, 32'd6, 5'd7, 1'b1);
      wait_valid("bp");
      e = exp_q[0];
      drive(1'b0, 1'b1, 32'd9, 32'd9, 5'd1);
      drive(1'b1, 1'b1, 32'd9, 32'd9, 5'd2);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_valid",  32'(resp_valid_o), 32'd1);
         chk("bp_result", resp_result_o, e.res);
         chk("bp_rd",     32'(resp_rd_o), 32'(e.rd));
         chk("bp_src",    32'(resp_src_o), 32'(e.src));
         chk("bp_busy",   32'(busy_o), 32'd1);
         chk("bp_ready0", 32'(req0_ready_o), 32'd0);
         chk("bp_ready1", 32'(req1_ready_o), 32'd0);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
      accept("bp");

      // Flush in flight: the killed result never appears
      issue(1'b0, 32'h80000000, 32'd7, 5'd9, 1'b0);
      @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("flush_no_valid", 32'(resp_valid_o), 32'd0);
         @(negedge clk);
      end
      chk("flush_busy_after", 32'(busy_o), 32'd0);
      drive(1'b0, 1'b1, 32'd1, 32'hDEADBEEF, 5'd4);
      flush_i = 1'b1;
      #1;
      chk("flush_idle_ready0", 32'(req0_ready_o), 32'd0);
      @(negedge clk);
      flush_i = 1'b0;
      n = swcnt_exp;
      issue(1'b0, 32'd1, 32'hDEADBEEF, 5'd4, 1'b1);
      wait_valid("after_flush");
      chk("after_flush_result_lit", resp_result_o, 32'hDEADBEEF);
      chk("after_flush_swap_cnt", 32'(swap_count_o), 32'(n));
      accept("after_flush");

      // Reset mid-operation
      ra = $urandom | 32'h1;
      rb = $urandom;
      issue(1'b1, ra, rb, 5'd12, 1'b0);
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      chk_all_zero("rst_mid");
      rst_i = 1'b0;
      exp_q.delete();
      swcnt_exp = 0;
      @(negedge clk);
      ra = $urandom;
      rb = $urandom;
      issue(1'b0, ra, rb, 5'd17, 1'b1);
      wait_valid("post_rst");
      chk("post_rst_swap_cnt", 32'(swap_count_o), 32'(swcnt_exp));
      accept("post_rst");
      chk("final_no_valid", 32'(resp_valid_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cbm_issue_arbiter.md
# cbm_issue_arbiter

Controller that shares one `column_bypass_multiplier` (CBM) instance between two issue-side requesters, e.g. the two pipes of the dual-issue core. It arbitrates round-robin and optionally swaps operands so the CBM iterates over the sparser one; the low 32 product bits are commutative, so the result is unchanged. It sequences the CBM start/done handshake, buffers one tagged result for writeback with backpressure, and supports pipeline flush.

## Interface
Parameters:
- `SWAP_EN`, 1: enable popcount-based operand swap.
- `CNT_W`, 16: width of the swap performance counter.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset is synchronous and active-high; also drives the CBM `rst_i`.
- `req0_valid_i` in 1: requester 0 has an operation.
- `req0_ready_o` out 1: requester 0 is granted this cycle.
- `req0_a_i`, `req0_b_i` in 32: requester 0 operands.
- `req0_rd_i` in 5: requester 0 destination register tag.
- `req1_*`: same set of ports as requester 0, for requester 1.
- `flush_i` in 1: kill the pending or in-flight operation.
- `resp_valid_o` out 1: a result is held.
- `resp_ready_i` in 1: writeback accepts the result.
- `resp_result_o` out 32: low 32 bits of a*b.
- `resp_rd_o` out 5: destination tag of the result.
- `resp_src_o` out 1: index of the requester that issued the result.
- `busy_o` out 1: the state is not IDLE.
- `swap_count_o` out CNT_W: number of issued operations that were swapped; saturating.

## Operation
- FSM states: IDLE, START, RUN, RESP.
- **IDLE**
  - `reqN_ready_o` = granted(N) & !flush_i.
  - Grant rule: if both requesters are valid, grant the one opposite `last_grant`; otherwise grant the valid one.
  - On handshake: capture operands, tag and source into the issue registers, update `last_grant`, go to START.
- **Swap**
  - Applies when SWAP_EN=1 and popcount(b) < popcount(a), computed combinationally on the granted inputs.
  - On swap: CBM `op_a` = b and `op_b` = a, and `swap_count_o` increments, saturating at all-ones.
  - On a tie, or with SWAP_EN=0, the operands are not swapped.
- **START**: CBM `start_i` is high for exactly this one cycle; go to RUN.
- **RUN**
  - Wait for CBM `done_o`.
  - On `done_o`, capture `result_o` into the response register and go to RESP.
  - If the kill flag is set, drop the result instead and go to IDLE.
- **RESP**
  - `resp_valid_o`=1; `resp_result_o`, `resp_rd_o` and `resp_src_o` stay stable.
  - On `resp_valid_o` & `resp_ready_i`, go to IDLE.
- **Flush**
  - In START or RUN: set the kill flag. The CBM cannot abort, so the controller still waits for `done_o`.
  - In RESP: go to IDLE next cycle without a transfer.
  - In IDLE: suppresses the grant that cycle.
  - Flush always wins over a simultaneous handshake.
- **Reset values**
  - All outputs are 0 and the state is IDLE.
  - Kill flag = 0, `last_grant` = 1 (so requester 0 wins first), `swap_count_o` = 0.
- Reset asserted mid-operation abandons the operation; no response is produced.

## Timing
- Handshake at edge T; CBM `start_i` is high in cycle T+1.
- CBM contract: `done_o` is a single-cycle pulse after popcount(`op_a`) busy cycles; the controller must tolerate any latency of 1 or more cycles.
- If `done_o` is sampled at edge D, `resp_valid_o` is high from D onward, until the transfer edge.
- Next grant is possible in the cycle after the response transfer. Throughput is one operation per (CBM latency + 3) cycles minimum.
- `reqN_ready_o` is combinational from valid, `flush_i` and state. All other outputs are registered.
- No more than one operation is ever outstanding, including a killed operation still in flight.

## Structure
- Shared package `cbm_pkg` holds:
  - the FSM state enum;
  - `XLEN=32` and `RD_W=5`;
  - the `popcount32` function, shared with the CBM benches.
- One sub-module: `column_bypass_multiplier`, instantiated internally.
  - Its `rd_idx_i` is tied off; the tag lives in the issue register.

## Test plan
- **Swap:** req0 a=0xFFFF0000, b=3, SWAP_EN=1.
  - CBM `op_a`=3, 2 busy cycles.
  - `resp_result_o`=0xFFFD0000, `resp_src_o`=0, `swap_count_o`=1.
- **Fairness:** both requesters valid every cycle after reset, 4 operations.
  - Grants go 0, 1, 0, 1.
  - Each `resp_rd_o` matches its issuing requester's tag.
- **Zero operand:** a=0, b=12345.
  - No swap, result 0, CBM latency 0 busy cycles.
- **Backpressure:** `resp_ready_i` held low for 5 cycles.
  - Response stays stable, both `reqN_ready_o` stay 0, `busy_o`=1.
- **Flush in flight:** a=0x80000000, b=7, `flush_i` pulsed in RUN.
  - No `resp_valid_o` for this operation.
  - The next request (a=1, b=0xDEADBEEF) returns 0xDEADBEEF, unswapped.
- **Reset mid-operation:** `rst_i` asserted in RUN.
  - All outputs are 0 the next cycle.
  - A following operation with random operands matches (a*b)[31:0].
